// File: rtl/apb_i2c_req_arbiter.sv
// Round-robin arbiter sharing the I2C controller's APB slave port between NREQ requesters.
// Enforces the register access map and bounds every ACCESS phase with a pready timeout.
module apb_i2c_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gnt_q, gnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [ADDR_W-1:0]   addr_a  [NREQ];
  logic [DATA_W-1:0]   wdata_a [NREQ];
  logic                found;
  logic [PW-1:0]       sel;
  logic [PW-1:0]       cand;
  logic                sel_legal;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: first pending requester strictly after the last grant.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    if (req_write[sel])
      sel_legal = (addr_a[sel] == ADDR_W'(2)) || (addr_a[sel] == ADDR_W'(4)) ||
                  (addr_a[sel] == ADDR_W'(6));
    else
      sel_legal = (addr_a[sel] == ADDR_W'(3)) || (addr_a[sel] == ADDR_W'(5));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[sel] = !preset;
          gnt_d          = sel;
          ptr_d          = sel;
          write_d        = req_write[sel];
          addr_d         = addr_a[sel];
          wdata_d        = req_write[sel] ? wdata_a[sel] : '0;
          rdata_d        = '0;
          cnt_d          = '0;
          err_d          = !sel_legal;
          state_d        = sel_legal ? S_SETUP : S_RESP;
        end
      end
      S_SETUP: begin
        psel    = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          if (!write_q) rdata_d = prdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Abort on the TIMEOUT-th unanswered ACCESS cycle.
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_rdata        = rdata_q;
        rsp_err          = err_q;
        cnt_d            = '0;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pwrite = psel ? write_q : 1'b0;
  assign paddr  = psel ? addr_q  : '0;
  assign pwdata = psel ? wdata_q : '0;

endmodule

// File: doc/apb_i2c_req_arbiter.md
Name: apb_i2c_req_arbiter

Overview:
- Shares the APB slave port of the I2C controller between NREQ local requesters, e.g. a CPU bridge and a DMA/sequencer.
- Arbitrates round-robin and drives exactly one APB transfer (SETUP then ACCESS) per granted request.
- Enforces the register access map: writes only to 2, 4 and 6; reads only from 3 and 5. Illegal requests complete with an error and generate no bus activity.
- Adds a pready timeout so a hung slave cannot lock out the requesters.

Parameters:
- NREQ, 2, number of requesters (2..4)
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- TIMEOUT, 16, maximum ACCESS cycles to wait for pready before aborting with error (>=1)

Ports:
- pclk  in  1  clock, rising edge
- preset  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request pending, one bit per requester; held until req_ready
- req_write  in  NREQ  1=write, 0=read, per requester
- req_addr  in  NREQ*ADDR_W  register address; requester i occupies slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  write data, sliced the same way
- req_ready  out  NREQ  one-cycle accept pulse to the granted requester
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  DATA_W  read data, valid while rsp_valid is high; 0 for writes and errors
- rsp_err  out  1  error flag, valid while rsp_valid is high
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all outputs 0, FSM in IDLE, timeout counter 0.
  - RR pointer set to NREQ-1, so requester 0 has first priority.
  - Any in-flight transfer is abandoned and no rsp_valid is issued for it.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from (pointer+1) mod NREQ.
  - In the same cycle: req_ready[g]=1; latch write, addr, wdata and g; set pointer=g.
  - Legal means (write and addr in {2,4,6}) or (read and addr in {3,5}).
  - Legal: go to SETUP. Illegal: go to RESP with err=1 and no psel.
- SETUP (one cycle):
  - psel=1, penable=0; pwrite, paddr, pwdata driven from the latch.
  - pwdata=0 for reads.
  - Next state: ACCESS.
- ACCESS:
  - psel=1, penable=1; address, control and data held stable.
  - The counter increments each cycle pready=0.
  - pready=1: capture prdata for reads, err=0, go to RESP.
  - Counter reaches TIMEOUT with pready still 0: err=1, rdata=0, go to RESP. The transfer is dropped: psel=0 and penable=0 in the next cycle.
- RESP (one cycle):
  - psel=0, penable=0.
  - rsp_valid[g]=1; rsp_rdata and rsp_err driven from the latch.
  - Next state: IDLE; the counter is cleared.
- Latency with a zero-wait-state slave:
  - accept in cycle n, SETUP n+1, ACCESS n+2, rsp_valid n+3, next accept n+4.
  - Throughput: one transaction per 4 cycles.
  - An illegal request gets rsp_valid at n+1.
- Handshake and arbitration rules:
  - Requests arriving while the FSM is busy wait; req_ready is never asserted outside IDLE.
  - Only one bit of req_ready or rsp_valid is ever set at a time.
  - A requester dropping req_valid before req_ready is legal and simply withdraws the request.
  - Simultaneous requests are resolved strictly by round-robin; there is no starvation.
- APB protocol invariants:
  - psel never rises together with penable.
  - penable is asserted only in the cycle after SETUP.
  - pready is ignored outside ACCESS.
  - An ACCESS phase never exceeds TIMEOUT cycles.

Test Plan:
- Single write: requester 0 writes addr 2, data 8'hA5, slave pready=1 immediately -> psel at cycle 1 with paddr=2, pwrite=1, pwdata=8'hA5; penable at cycle 2; rsp_valid[0] at cycle 3 with err=0.
- Read with wait states: requester 1 reads addr 5, slave holds pready low 3 cycles then returns 8'h3C -> ACCESS lasts 4 cycles; rsp_valid[1] with rsp_rdata=8'h3C, err=0.
- Illegal accesses: write to addr 3, read from addr 4, write to addr 7 -> psel stays 0 throughout; rsp_valid one cycle after req_ready each time, with err=1 and rdata=0.
- Fairness: both requesters hold req_valid continuously for 6 legal transfers -> grants alternate 0,1,0,1,0,1; each transaction spans exactly 4 cycles.
- Timeout: slave never raises pready, TIMEOUT=16 -> penable high for exactly 16 cycles, then rsp_err=1 and psel drops; the next queued request is accepted afterwards.
- Reset mid-ACCESS: assert preset while penable=1 -> psel, penable and rsp_valid go 0 without waiting for a clock edge. After release, requester 0 wins a simultaneous 0/1 request.
